// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the PIO blocks: register word addresses, edge-type codes
// and the edge-detect helper used by the button PIO.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                                input logic [31:0] prv,
                                                input int          etype);
        logic [31:0] result;
        case (etype)
            EDGE_RISING:  result = cur & ~prv;
            EDGE_FALLING: result = ~cur & prv;
            default:      result = cur ^ prv;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// Single-bit debounce filter: output follows the input only after it has
// disagreed with the output for DEBOUNCE_CYCLES consecutive clocks.
module soc_system_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic d_out
);

    localparam int            CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            d_out <= 1'(IDLE_LEVEL);
        end else if (d_in == d_out) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            d_out <= d_in;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/soc_system_button_pio.sv
// Avalon-MM button/key PIO with edge capture and level interrupt.
// Define SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN to insert a per-bit debounce filter.
module soc_system_button_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{1'(IDLE_LEVEL)}};

    logic [WIDTH-1:0] sync1, sync2, filtered, prev;
    logic [WIDTH-1:0] edge_det, irqmask, edgecapture, clr_mask, wr_bits;
    logic             wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_VEC;
            sync2 <= IDLE_VEC;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        soc_system_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .d_in    (sync2[gi]),
            .d_out   (filtered[gi])
        );
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign filtered = sync2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= IDLE_VEC;
        else          prev <= filtered;
    end

    assign edge_det = WIDTH'(edge_detect(32'(filtered), 32'(prev), EDGE_TYPE));

    assign wr_en    = chipselect && !write_n;
    assign wr_bits  = writedata[WIDTH-1:0];
    assign clr_mask = (wr_en && address == ADDR_EDGECAP) ? wr_bits : '0;

    if (WIDTH < 32) begin : g_unused_hi
        logic unused_writedata_hi;
        assign unused_writedata_hi = ^writedata[31:WIDTH];
    end

    // A capture in the same clock as a clear-write wins, so no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) irqmask <= wr_bits;
            edgecapture <= (edgecapture & ~clr_mask) | edge_det;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(filtered);
            ADDR_IRQMASK: readdata = 32'(irqmask);
            ADDR_EDGECAP: readdata = 32'(edgecapture);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: doc/soc_system_button_pio.md
SOC_SYSTEM_BUTTON_PIO -- requirements
Module: soc_system_button_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input bits (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 1: capture edge (0 rising, 1 falling, 2 any).
REQ-003 SHALL have parameter IDLE_LEVEL, default 1: reset value of every internal input-path register bit.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 16: filter length in clocks (used only with the debounce macro).
REQ-005 SHALL have port clk input 1: clock; all state on rising edge.
REQ-006 SHALL have port reset_n input 1: reset, asynchronous, active-low.
REQ-007 SHALL have port address input 2: Avalon-MM word address.
REQ-008 SHALL have port chipselect input 1: slave select.
REQ-009 SHALL have port write_n input 1: active-low write strobe.
REQ-010 SHALL have port writedata input 32: write data.
REQ-011 SHALL have port readdata output 32: read data, zero-wait, combinational from address.
REQ-012 SHALL have port in_port input WIDTH: asynchronous external inputs (keys).
REQ-013 SHALL have port irq output 1: level interrupt, active-high.

Function
REQ-014 SHALL pass in_port through a 2-flop synchronizer per bit before any use.
REQ-015 SHALL define the filtered value as the synchronizer output (or the debounced value, REQ-031).
REQ-016 SHALL register the filtered value into prev each clock; edge = filtered&~prev (rising), ~filtered&prev (falling), filtered^prev (any).
REQ-017 SHALL set edgecapture[i] on the clock following edge[i] assertion; bits stay set until cleared.
REQ-018 Register map SHALL be: addr 0 data (RO, filtered value); addr 1 reserved (reads 0, writes ignored); addr 2 irqmask (RW, WIDTH bits); addr 3 edgecapture (read; write-1-to-clear per bit).
REQ-019 Write SHALL occur when chipselect=1 and write_n=0; writedata bits above WIDTH-1 ignored.
REQ-020 readdata SHALL be zero-extended register selected by address, valid same cycle, independent of chipselect.
REQ-021 irq SHALL equal |(edgecapture & irqmask), combinational from registers.
REQ-022 Latency (no debounce): in_port change sampled at edge k -> data readable after edge k+1 -> edgecapture/irq set after edge k+2.
REQ-023 Simultaneous clear-write and new edge on same bit SHALL leave that bit set (set wins); other written-1 bits clear.
REQ-024 Writes to addr 0 SHALL be ignored.
REQ-025 Input pulses shorter than one clock MAY be missed; pulses of >=2 clocks SHALL be captured exactly once per qualifying edge.

Reset
REQ-026 On reset_n low, synchronizer, filtered, prev and debounce state SHALL go to {WIDTH{IDLE_LEVEL}} / 0 counters immediately.
REQ-027 On reset, irqmask=0, edgecapture=0, irq=0, readdata at addr 0 = {WIDTH{IDLE_LEVEL}} zero-extended.
REQ-028 Reset asserted mid-operation SHALL discard pending edges and counts; no edge SHALL be generated by reset release itself when in_port equals IDLE_LEVEL.

Configuration
REQ-029 Macro SOC_SYSTEM_BUTTON_PIO_DEBOUNCE_EN SHALL select debounce inclusion.
REQ-030 Without it, filtered = synchronizer output; DEBOUNCE_CYCLES unused; no counters synthesized.
REQ-031 With it, per bit: counter increments while synchronized bit != filtered bit, resets to 0 when equal; filtered bit toggles and counter clears when counter reaches DEBOUNCE_CYCLES-1; latency of REQ-022 grows by DEBOUNCE_CYCLES.

Structure
REQ-032 Shared package soc_system_pio_pkg SHALL hold register address constants (DATA=0, IRQMASK=2, EDGECAP=3) and edge-type constants.
REQ-033 Debounce SHALL be sub-module soc_system_pio_debounce (one bit, parameter DEBOUNCE_CYCLES), instantiated WIDTH times under the macro.

Verification
REQ-034 Reset, read addr 0/2/3 -> 0xF, 0x0, 0x0; irq=0.
REQ-035 EDGE_TYPE=1, irqmask=0x1, drive in_port 0xF->0xE for 5 clocks -> edgecapture=0x1, irq=1 after edge k+2; return to 0xF -> no new capture.
REQ-036 edgecapture=0x3, write addr 3 data 0x1 -> reads 0x2; irq follows mask.
REQ-037 Clear-write of bit0 in same cycle as new falling edge on bit0 -> bit0 remains 1.
REQ-038 With DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-clock glitch on bit2 -> no capture; 20-clock low -> one capture, data bit2=0.
REQ-039 Assert reset_n mid-debounce with edgecapture=0xF -> all registers per REQ-027, no capture after release with in_port=0xF.
